load_store_unit: RTL

- MEM-stage front end of the data path.
- Takes one load/store request at a time from the pipeline and converts it to word address, byte mask and lane-aligned write data for data_memory.
- Tracks data_memory's synchronous read latency and its read-modify-write busy window; holds address stable for the whole access.
- Returns aligned, sign/zero-extended load data or store completion with a single response pulse per request.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_load_align.sv | 37 +++
 rtl/load_store_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, funct3 encodings and byte-mask helper for the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOAD_RSP   = 2'd1,
    S_STORE_WAIT = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-lane write mask for a store of the given size at the given offset.
  function automatic logic [3:0] lsu_mask(input logic [2:0] funct3, input logic [1:0] offset);
    logic [3:0] mask;
    case (funct3)
      F3_B, F3_BU: mask = 4'b0001 << offset;
      F3_H, F3_HU: mask = 4'b0011 << offset;
      default:     mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational lane extraction and sign/zero extension of loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic [width_p-1:0] word_i,
  input  logic [1:0]         offset_i,
  input  logic [2:0]         funct3_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] w_shifted;

  // Bring the addressed lane down to bit 0; word loads are always offset 0.
  assign w_shifted = word_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = w_shifted;
    case (funct3_i)
      F3_B:    data_o = {{(width_p-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   data_o = {{(width_p-8){1'b0}}, w_shifted[7:0]};
      F3_H:    data_o = {{(width_p-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   data_o = {{(width_p-16){1'b0}}, w_shifted[15:0]};
      default: data_o = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage load/store front end for data_memory. Optional
//               performance counters are built when LSU_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_store_i,
  input  logic [2:0]         req_funct3_i,
  input  logic [width_p-1:0] req_addr_i,
  input  logic [width_p-1:0] req_wdata_i,
  output logic               rsp_valid_o,
  output logic [width_p-1:0] rsp_data_o,
  output logic               rsp_error_o,
  output logic [width_p-1:0] mem_addr_o,
  output logic               mem_read_enable_o,
  output logic               mem_write_enable_o,
  output logic [width_p-1:0] mem_write_data_o,
  output logic [3:0]         mem_write_mask_o,
  input  logic [width_p-1:0] mem_read_data_i,
  input  logic               mem_busy_i,
  output logic [31:0]        load_count_o,
  output logic [31:0]        store_count_o,
  output logic [31:0]        stall_cycles_o
);

  state_t             r_state;
  state_t             w_next_state;
  logic [width_p-1:0] r_addr;
  logic [2:0]         r_funct3;
  logic [1:0]         r_offset;
  logic               r_error;

  logic               w_accept;
  logic               w_error;
  logic               w_full_word;
  logic [1:0]         w_offset;
  logic [width_p-1:0] w_load_data;

  assign w_offset    = req_addr_i[1:0];
  assign w_accept    = (r_state == S_IDLE) && req_valid_i && !reset_i;
  assign w_full_word = (req_funct3_i == F3_W);

  always_comb begin
    w_error = 1'b0;
    case (req_funct3_i)
      F3_B, F3_BU: w_error = 1'b0;
      F3_H, F3_HU: w_error = req_addr_i[0];
      F3_W:        w_error = (w_offset != 2'b00);
      default:     w_error = 1'b1;
    endcase
    // Only signed sizes exist for stores; the unsigned encodings are illegal.
    if (req_store_i && req_funct3_i[2]) begin
      w_error = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_addr   <= '0;
      r_funct3 <= 3'b000;
      r_offset <= 2'b00;
      r_error  <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= req_addr_i;
      r_funct3 <= req_funct3_i;
      r_offset <= w_offset;
      r_error  <= w_error;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_error) begin
            w_next_state = S_DONE;
          end else if (!req_store_i) begin
            w_next_state = S_LOAD_RSP;
          end else if (w_full_word) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_STORE_WAIT;
          end
        end
      end
      S_LOAD_RSP:   w_next_state = S_IDLE;
      S_STORE_WAIT: if (!mem_busy_i) w_next_state = S_IDLE;
      S_DONE:       w_next_state = S_IDLE;
      default:      w_next_state = S_IDLE;
    endcase
  end

  lsu_load_align #(
    .width_p (width_p)
  ) u_load_align (
    .word_i   (mem_read_data_i),
    .offset_i (r_offset),
    .funct3_i (r_funct3),
    .data_o   (w_load_data)
  );

  // Output logic
  always_comb begin
    req_ready_o        = 1'b0;
    rsp_valid_o        = 1'b0;
    rsp_data_o         = '0;
    rsp_error_o        = 1'b0;
    mem_read_enable_o  = 1'b0;
    mem_write_enable_o = 1'b0;
    mem_write_data_o   = '0;
    mem_write_mask_o   = 4'b0000;
    mem_addr_o         = r_addr;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        mem_addr_o  = reset_i ? '0 : req_addr_i;
        if (w_accept && !w_error) begin
          if (req_store_i) begin
            mem_write_enable_o = 1'b1;
            mem_write_mask_o   = lsu_mask(req_funct3_i, w_offset);
            mem_write_data_o   = req_wdata_i << {w_offset, 3'b000};
          end else begin
            mem_read_enable_o = 1'b1;
          end
        end
      end
      S_LOAD_RSP: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = w_load_data;
      end
      S_STORE_WAIT: begin
        // data_memory drops busy in its write-back cycle, using our held address.
        rsp_valid_o = !mem_busy_i;
      end
      S_DONE: begin
        rsp_valid_o = 1'b1;
        rsp_error_o = r_error;
      end
      default: begin
        rsp_valid_o = 1'b0;
      end
    endcase
  end

`ifdef LSU_PERF_CNT_EN
  logic [31:0] r_load_count;
  logic [31:0] r_store_count;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_load_count   <= 32'd0;
      r_store_count  <= 32'd0;
      r_stall_cycles <= 32'd0;
    end else begin
      if (w_accept && !w_error && !req_store_i) begin
        r_load_count <= r_load_count + 32'd1;
      end
      if (w_accept && !w_error && req_store_i) begin
        r_store_count <= r_store_count + 32'd1;
      end
      if (req_valid_i && !req_ready_o) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign load_count_o   = r_load_count;
  assign store_count_o  = r_store_count;
  assign stall_cycles_o = r_stall_cycles;
`else
  assign load_count_o   = 32'd0;
  assign store_count_o  = 32'd0;
  assign stall_cycles_o = 32'd0;
`endif

endmodule

`default_nettype wire
